control_unit: RTL and testbench

Hardwired Moore control sequencer that drives the DataPath control inputs, replacing hand-written per-instruction stimulus. It steps fetch (T0–T2), decodes the 5-bit opcode from the IR, then issues the execute T-steps for each instruction class. It is the producer side of the DataPath control interface, and sits beside DataPath in the top-level CPU.

---
 rtl/cpu_ctrl_pkg.sv | 41 ++++
 rtl/op_class_decode.sv | 32 +++
 rtl/control_unit.sv | 142 ++++++++++++++
 tb/tb_control_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, ALU code, state and instruction-class definitions for the
// hardwired control sequencer.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b01010;
    localparam logic [4:0] ALU_OR  = 5'b01011;

    localparam logic [3:0] ST_RST  = 4'd0;
    localparam logic [3:0] ST_T0   = 4'd1;
    localparam logic [3:0] ST_T1   = 4'd2;
    localparam logic [3:0] ST_T2   = 4'd3;
    localparam logic [3:0] ST_T3   = 4'd4;
    localparam logic [3:0] ST_T4   = 4'd5;
    localparam logic [3:0] ST_T5   = 4'd6;
    localparam logic [3:0] ST_T6   = 4'd7;
    localparam logic [3:0] ST_T7   = 4'd8;
    localparam logic [3:0] ST_HALT = 4'd9;

    typedef enum logic [3:0] {
        CL_RTYPE, CL_IMM, CL_LDI, CL_LD, CL_ST, CL_BR,
        CL_JR, CL_JAL, CL_IN, CL_OUT, CL_NOP, CL_HALT
    } op_class_t;

endpackage

// File: rtl/op_class_decode.sv
// Maps a 5-bit opcode onto the instruction class that selects the execute
// sequence; anything without its own sequence behaves as a nop.
module op_class_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = CL_NOP;
        if (opcode >= OP_ADD && opcode <= OP_OR)
            op_class = CL_RTYPE;
        else if (opcode >= OP_ADDI && opcode <= OP_ORI)
            op_class = CL_IMM;
        else begin
            case (opcode)
                OP_LDI:  op_class = CL_LDI;
                OP_LD:   op_class = CL_LD;
                OP_ST:   op_class = CL_ST;
                OP_BR:   op_class = CL_BR;
                OP_JR:   op_class = CL_JR;
                OP_JAL:  op_class = CL_JAL;
                OP_IN:   op_class = CL_IN;
                OP_OUT:  op_class = CL_OUT;
                OP_HALT: op_class = CL_HALT;
                default: op_class = CL_NOP;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Moore control sequencer for the DataPath: fetch T0-T2, then per-class
// execute steps. State advances on the falling clock edge so DataPath sees
// stable controls at its rising-edge capture.
//
// state | meaning
// RST   | held in reset, all controls low
// T0-T2 | instruction fetch (PC->MAR, memory read, MDR->IR)
// T3-T7 | execute steps, sequence chosen by latched opcode class
// HALT  | stopped until clear, all controls low
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter logic [4:0] ADD_CODE = 5'b00011
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic        PCout, IncPC, ZLOout, ZLOin, ZHIout, Cout, MDRout,
    output logic        RAMenable, MARin, PCin, MDRin, IRin, Yin,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout, R15in,
    output logic        read, write, conin, OutPortenable, PortInout,
    output logic [4:0]  aluControl,
    output logic        run
);

    logic [3:0] state, state_nxt;
    logic [4:0] opcode_q, op_sel;
    op_class_t  op_class;
    logic       unused_ir_bits;

    assign unused_ir_bits = ^ir[26:0];

    // During T2 the opcode is still in flight, so decode ir directly there.
    assign op_sel = (state == ST_T2) ? ir[31:27] : opcode_q;

    op_class_decode u_dec (
        .opcode   (op_sel),
        .op_class (op_class)
    );

    always_ff @(negedge clock or negedge clear) begin
        if (!clear) begin
            state    <= ST_RST;
            opcode_q <= 5'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_T2)
                opcode_q <= ir[31:27];
        end
    end

    always_comb begin
        state_nxt = ST_RST;
        case (state)
            ST_RST:  state_nxt = ST_T0;
            ST_T0:   state_nxt = ST_T1;
            ST_T1:   state_nxt = ST_T2;
            ST_T2:   state_nxt = (op_class == CL_HALT) ? ST_HALT :
                                 (op_class == CL_NOP)  ? ST_T0 : ST_T3;
            ST_T3:   state_nxt = (op_class inside {CL_JR, CL_IN, CL_OUT}) ? ST_T0 : ST_T4;
            ST_T4:   state_nxt = (op_class == CL_JAL) ? ST_T0 : ST_T5;
            ST_T5:   state_nxt = (op_class inside {CL_LD, CL_ST, CL_BR}) ? ST_T6 : ST_T0;
            ST_T6:   state_nxt = (op_class == CL_BR) ? ST_T0 : ST_T7;
            ST_T7:   state_nxt = ST_T0;
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_RST;
        endcase
    end

    always_comb begin
        {PCout, IncPC, ZLOout, ZLOin, ZHIout, Cout, MDRout} = '0;
        {RAMenable, MARin, PCin, MDRin, IRin, Yin} = '0;
        {Gra, Grb, Grc, Rin, Rout, BAout, R15in} = '0;
        {read, write, conin, OutPortenable, PortInout} = '0;
        aluControl = 5'd0;
        run = (state != ST_RST) && (state != ST_HALT);
        case (state)
            ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
            ST_T1: begin read = 1'b1; RAMenable = 1'b1; MDRin = 1'b1; end
            ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            ST_T3: begin
                case (op_class)
                    CL_RTYPE, CL_IMM: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CL_LDI, CL_LD, CL_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    CL_BR:  begin Gra = 1'b1; Rout = 1'b1; conin = 1'b1; end
                    CL_JR:  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    CL_JAL: begin R15in = 1'b1; PCout = 1'b1; end
                    CL_IN:  begin PortInout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_OUT: begin Gra = 1'b1; Rout = 1'b1; OutPortenable = 1'b1; end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (op_class)
                    CL_RTYPE: begin
                        Grc = 1'b1; Rout = 1'b1; ZLOin = 1'b1; aluControl = opcode_q;
                    end
                    CL_IMM: begin
                        Cout = 1'b1; ZLOin = 1'b1;
                        case (opcode_q)
                            OP_ANDI: aluControl = ALU_AND;
                            OP_ORI:  aluControl = ALU_OR;
                            default: aluControl = ADD_CODE;
                        endcase
                    end
                    CL_LDI, CL_LD, CL_ST: begin
                        Cout = 1'b1; ZLOin = 1'b1; aluControl = ADD_CODE;
                    end
                    CL_BR:  begin PCout = 1'b1; Yin = 1'b1; end
                    CL_JAL: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (op_class)
                    CL_RTYPE, CL_IMM, CL_LDI: begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_LD, CL_ST: begin ZLOout = 1'b1; MARin = 1'b1; end
                    CL_BR: begin Cout = 1'b1; ZLOin = 1'b1; aluControl = ADD_CODE; end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (op_class)
                    CL_LD: begin read = 1'b1; RAMenable = 1'b1; MDRin = 1'b1; end
                    CL_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    CL_BR: begin ZLOout = 1'b1; PCin = con_ff; end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (op_class)
                    CL_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_ST: begin write = 1'b1; RAMenable = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle vector table of expected
// control words plus hand-written reset-mid-instruction sequence.
module tb_control_unit;

    logic        clock, clear, con_ff;
    logic [31:0] ir;
    logic        PCout, IncPC, ZLOout, ZLOin, ZHIout, Cout, MDRout;
    logic        RAMenable, MARin, PCin, MDRin, IRin, Yin;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, R15in;
    logic        read, write, conin, OutPortenable, PortInout, run;
    logic [4:0]  aluControl;
    logic [25:0] act;

    control_unit dut (
        .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff),
        .PCout(PCout), .IncPC(IncPC), .ZLOout(ZLOout), .ZLOin(ZLOin),
        .ZHIout(ZHIout), .Cout(Cout), .MDRout(MDRout), .RAMenable(RAMenable),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .R15in(R15in), .read(read), .write(write),
        .conin(conin), .OutPortenable(OutPortenable), .PortInout(PortInout),
        .aluControl(aluControl), .run(run)
    );

    assign act = {run, PortInout, OutPortenable, conin, write, read, R15in,
                  BAout, Rout, Rin, Grc, Grb, Gra, Yin, IRin, MDRin, PCin,
                  MARin, RAMenable, MDRout, Cout, ZHIout, ZLOin, ZLOout,
                  IncPC, PCout};

    localparam logic [25:0] PCOUT = 26'h1 << 0,  INCPC = 26'h1 << 1;
    localparam logic [25:0] ZLOOUT = 26'h1 << 2, ZLOIN = 26'h1 << 3;
    localparam logic [25:0] COUT = 26'h1 << 5,   MDROUT = 26'h1 << 6;
    localparam logic [25:0] RAMEN = 26'h1 << 7,  MARIN = 26'h1 << 8;
    localparam logic [25:0] PCIN = 26'h1 << 9,   MDRIN = 26'h1 << 10;
    localparam logic [25:0] IRIN = 26'h1 << 11,  YIN = 26'h1 << 12;
    localparam logic [25:0] GRA = 26'h1 << 13,   GRB = 26'h1 << 14;
    localparam logic [25:0] GRC = 26'h1 << 15,   RIN = 26'h1 << 16;
    localparam logic [25:0] ROUT = 26'h1 << 17,  BAOUT = 26'h1 << 18;
    localparam logic [25:0] R15IN = 26'h1 << 19, READ = 26'h1 << 20;
    localparam logic [25:0] WRITE = 26'h1 << 21, CONIN = 26'h1 << 22;
    localparam logic [25:0] OUTPE = 26'h1 << 23, PORTIO = 26'h1 << 24;
    localparam logic [25:0] RUN = 26'h1 << 25;
    localparam logic [31:0] JUNK = 32'hD8000000;

    typedef struct {
        logic [31:0] ir;
        logic        con_ff;
        logic [25:0] ctl;
        logic [4:0]  alu;
        string       nm;
    } vec_t;

    vec_t vq[$];
    int   n_pass = 0;
    int   n_total = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] irw(input logic [4:0] op);
        return {op, 27'h0123456};
    endfunction

    task automatic check(input string nm, input logic [25:0] ec, input logic [4:0] ea);
        n_total++;
        if (act === ec && aluControl === ea)
            n_pass++;
        else
            $display("FAIL %s: ctl=%h alu=%b, expected ctl=%h alu=%b", nm, act, aluControl, ec, ea);
    endtask

    task automatic ex(input logic [31:0] i, input logic c, input logic [25:0] ctl,
                      input logic [4:0] alu, input string nm);
        vec_t v;
        v.ir = i; v.con_ff = c; v.ctl = ctl | RUN; v.alu = alu; v.nm = nm;
        vq.push_back(v);
    endtask

    task automatic idle(input string nm);
        vec_t v;
        v.ir = irw(5'b11010); v.con_ff = 1'b0; v.ctl = '0; v.alu = '0; v.nm = nm;
        vq.push_back(v);
    endtask

    task automatic fetch(input logic [31:0] i, input string nm);
        ex(i, 1'b0, PCOUT | MARIN | INCPC, 5'd0, {nm, ".T0"});
        ex(i, 1'b0, READ | RAMEN | MDRIN, 5'd0, {nm, ".T1"});
        ex(i, 1'b0, MDROUT | IRIN, 5'd0, {nm, ".T2"});
    endtask

    // Each record covers one negedge-to-negedge cycle; checked mid-cycle.
    task automatic run_vectors();
        foreach (vq[k]) begin
            @(negedge clock);
            #1;
            ir = vq[k].ir;
            con_ff = vq[k].con_ff;
            @(posedge clock);
            #1;
            check(vq[k].nm, vq[k].ctl, vq[k].alu);
        end
        vq.delete();
    endtask

    task automatic alu_op(input logic [4:0] op, input logic [25:0] t4, input logic [4:0] alu,
                          input string nm);
        fetch(irw(op), nm);
        ex(JUNK, 1'b0, (op >= 5'b01100 || op == 5'b00011) ? GRB | ROUT | YIN : GRB | ROUT | YIN,
           5'd0, {nm, ".T3"});
        ex(JUNK, 1'b0, t4 | ZLOIN, alu, {nm, ".T4"});
        ex(JUNK, 1'b0, ZLOOUT | GRA | RIN, 5'd0, {nm, ".T5"});
    endtask

    task automatic br_op(input logic c, input string nm);
        fetch(irw(5'b10011), nm);
        ex(irw(5'b10011), ~c, GRA | ROUT | CONIN, 5'd0, {nm, ".T3"});
        ex(irw(5'b10011), ~c, PCOUT | YIN, 5'd0, {nm, ".T4"});
        ex(irw(5'b10011), ~c, COUT | ZLOIN, 5'b00011, {nm, ".T5"});
        ex(irw(5'b10011), c, ZLOOUT | (c ? PCIN : 26'h0), 5'd0, {nm, ".T6"});
    endtask

    initial begin
        clear = 1'b0;
        ir = 32'h0;
        con_ff = 1'b0;

        @(posedge clock);
        #1 check("reset_state", 26'h0, 5'd0);
        @(negedge clock);
        #1 clear = 1'b1;

        alu_op(5'b00011, GRC | ROUT, 5'b00011, "add");
        alu_op(5'b00100, GRC | ROUT, 5'b00100, "sub");
        alu_op(5'b01001, GRC | ROUT, 5'b01001, "ror");
        alu_op(5'b01100, COUT, 5'b00011, "addi");
        alu_op(5'b01101, COUT, 5'b01010, "andi");
        alu_op(5'b01110, COUT, 5'b01011, "ori");

        fetch(irw(5'b00001), "ldi");
        ex(JUNK, 1'b0, GRB | BAOUT | YIN, 5'd0, "ldi.T3");
        ex(JUNK, 1'b0, COUT | ZLOIN, 5'b00011, "ldi.T4");
        ex(JUNK, 1'b0, ZLOOUT | GRA | RIN, 5'd0, "ldi.T5");

        fetch(irw(5'b00010), "st");
        ex(JUNK, 1'b0, GRB | BAOUT | YIN, 5'd0, "st.T3");
        ex(JUNK, 1'b0, COUT | ZLOIN, 5'b00011, "st.T4");
        ex(JUNK, 1'b0, ZLOOUT | MARIN, 5'd0, "st.T5");
        ex(JUNK, 1'b0, GRA | ROUT | MDRIN, 5'd0, "st.T6");
        ex(JUNK, 1'b0, WRITE | RAMEN, 5'd0, "st.T7");

        fetch(irw(5'b00000), "ld");
        ex(JUNK, 1'b0, GRB | BAOUT | YIN, 5'd0, "ld.T3");
        ex(JUNK, 1'b0, COUT | ZLOIN, 5'b00011, "ld.T4");
        ex(JUNK, 1'b0, ZLOOUT | MARIN, 5'd0, "ld.T5");
        ex(JUNK, 1'b0, READ | RAMEN | MDRIN, 5'd0, "ld.T6");
        ex(JUNK, 1'b0, MDROUT | GRA | RIN, 5'd0, "ld.T7");

        br_op(1'b1, "br_taken");
        br_op(1'b0, "br_not_taken");

        fetch(irw(5'b10100), "jr");
        ex(JUNK, 1'b0, GRA | ROUT | PCIN, 5'd0, "jr.T3");

        fetch(32'hA9000000, "jal");
        ex(JUNK, 1'b0, R15IN | PCOUT, 5'd0, "jal.T3");
        ex(JUNK, 1'b0, GRA | ROUT | PCIN, 5'd0, "jal.T4");

        fetch(irw(5'b10110), "in");
        ex(JUNK, 1'b0, PORTIO | GRA | RIN, 5'd0, "in.T3");
        fetch(irw(5'b10111), "out");
        ex(JUNK, 1'b0, GRA | ROUT | OUTPE, 5'd0, "out.T3");

        fetch(irw(5'b11010), "nop");
        fetch(irw(5'b11100), "op11100");
        fetch(irw(5'b01111), "mul");

        fetch(irw(5'b11011), "halt");
        for (int k = 0; k < 20; k++) idle($sformatf("halt_hold%0d", k));
        run_vectors();

        // Reset from HALT, then abort a jal in T3 with an asynchronous clear.
        clear = 1'b0;
        #1 check("clear_from_halt", 26'h0, 5'd0);
        @(negedge clock);
        #1 clear = 1'b1;
        fetch(32'hA9000000, "jal2");
        ex(32'hA9000000, 1'b0, R15IN | PCOUT, 5'd0, "jal2.T3");
        run_vectors();
        #2 clear = 1'b0;
        #1 check("clear_mid_jal_async", 26'h0, 5'd0);
        @(negedge clock);
        @(posedge clock);
        #1 check("clear_held_rst", 26'h0, 5'd0);
        @(negedge clock);
        #1 clear = 1'b1;
        @(posedge clock);
        #1 check("clear_release_still_rst", 26'h0, 5'd0);
        @(negedge clock);
        @(posedge clock);
        #1 check("post_clear.T0", PCOUT | MARIN | INCPC | RUN, 5'd0);
        ex(irw(5'b10110), 1'b0, READ | RAMEN | MDRIN, 5'd0, "post_clear.T1");
        ex(irw(5'b10110), 1'b0, MDROUT | IRIN, 5'd0, "post_clear.T2");
        ex(JUNK, 1'b0, PORTIO | GRA | RIN, 5'd0, "post_clear_in.T3");
        fetch(irw(5'b11010), "final_nop");
        run_vectors();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
